// File: rtl/acc_seq_ctrl_pkg.sv
// Shared encodings for the accumulator sequencer, datapath and bench.
package acc_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_HALT   = 3'd4,
        ST_FAULT  = 3'd5
    } state_t;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LDI   = 4'h1;
    localparam logic [3:0] OP_ADD   = 4'h2;
    localparam logic [3:0] OP_SUB   = 4'h3;
    localparam logic [3:0] OP_AND   = 4'h4;
    localparam logic [3:0] OP_OR    = 4'h5;
    localparam logic [3:0] OP_MOV   = 4'h6;
    localparam logic [3:0] OP_MVA   = 4'h7;
    localparam logic [3:0] OP_LW    = 4'h8;
    localparam logic [3:0] OP_SW    = 4'h9;
    localparam logic [3:0] OP_BEQZ  = 4'hA;
    localparam logic [3:0] OP_JMP   = 4'hB;
    localparam logic [3:0] OP_FLG   = 4'hC;
    localparam logic [3:0] OP_ILL_D = 4'hD;
    localparam logic [3:0] OP_ILL_E = 4'hE;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [1:0] ACC_SRC_ALU = 2'd0;
    localparam logic [1:0] ACC_SRC_EXT = 2'd1;
    localparam logic [1:0] ACC_SRC_MEM = 2'd2;
    localparam logic [1:0] ACC_SRC_REG = 2'd3;

    localparam logic [1:0] PC_SRC_INC = 2'd0;
    localparam logic [1:0] PC_SRC_REL = 2'd1;
    localparam logic [1:0] PC_SRC_ABS = 2'd2;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_AND = 2'd2;
    localparam logic [1:0] ALU_OR  = 2'd3;

    localparam logic EXT_SEXT8 = 1'b0;
    localparam logic EXT_FLAG  = 1'b1;

endpackage

// File: rtl/acc_mem_wait.sv
// Counts unacknowledged memory-request cycles and flags a timeout.
module acc_mem_wait #(
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned WAIT_W   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic ready,
    input  logic clear,
    output logic timeout
);

    logic [WAIT_W-1:0] count;

    // Wait counter: zero outside an access, one step per stalled request cycle.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (req && !ready) begin
            count <= count + WAIT_W'(1);
        end
    end

    // Ready in the same cycle the limit is reached still completes the access.
    assign timeout = req && !ready && (count == WAIT_W'(MAX_WAIT));

endmodule

// File: rtl/acc_seq_ctrl.sv
// Multi-cycle control sequencer for the 16-bit accumulator datapath.
module acc_seq_ctrl
    import acc_seq_ctrl_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned WAIT_W   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] opcode,
    input  logic       acc_zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       addr_sel,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       acc_we,
    output logic [1:0] acc_src,
    output logic [1:0] alu_op,
    output logic       ext_sel,
    output logic       reg_we,
    output logic       halted,
    output logic       fault,
    output logic [2:0] state_dbg
);

    state_t state;
    logic   in_access;
    logic   timeout;

    // A memory access is live only in FETCH and MEM; a completed handshake restarts the count.
    assign in_access = (state == ST_FETCH) || (state == ST_MEM);

    acc_mem_wait #(
        .MAX_WAIT (MAX_WAIT),
        .WAIT_W   (WAIT_W)
    ) u_mem_wait (
        .clk     (clk),
        .rst     (rst),
        .req     (mem_req),
        .ready   (mem_ready),
        .clear   (!in_access || mem_ready),
        .timeout (timeout)
    );

    // Instruction sequencing; HALT and FAULT are left only through reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_FETCH;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (mem_ready) begin
                        state <= ST_DECODE;
                    end else if (timeout) begin
                        state <= ST_FAULT;
                    end
                end
                ST_DECODE: state <= ST_EXEC;
                ST_EXEC: begin
                    case (opcode)
                        OP_NOP:             state <= ST_FETCH;
                        OP_LW, OP_SW:       state <= ST_MEM;
                        OP_HALT:            state <= ST_HALT;
                        OP_ILL_D, OP_ILL_E: state <= ST_FAULT;
                        default:            state <= ST_FETCH;
                    endcase
                end
                ST_MEM: begin
                    if (mem_ready) begin
                        state <= ST_FETCH;
                    end else if (timeout) begin
                        state <= ST_FAULT;
                    end
                end
                ST_HALT:  state <= ST_HALT;
                ST_FAULT: state <= ST_FAULT;
                default:  state <= ST_FAULT;
            endcase
        end
    end

    // Datapath controls decoded from state, opcode and mem_ready; all quiet during reset.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_src    = PC_SRC_INC;
        acc_we    = 1'b0;
        acc_src   = ACC_SRC_ALU;
        alu_op    = ALU_ADD;
        ext_sel   = EXT_SEXT8;
        reg_we    = 1'b0;
        halted    = 1'b0;
        fault     = 1'b0;
        state_dbg = 3'd0;
        if (!rst) begin
            state_dbg = state;
            case (state)
                ST_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_we = 1'b1;
                        pc_we = 1'b1;
                    end
                end
                ST_EXEC: begin
                    case (opcode)
                        OP_LDI: begin
                            acc_we  = 1'b1;
                            acc_src = ACC_SRC_EXT;
                        end
                        OP_ADD: begin
                            acc_we = 1'b1;
                            alu_op = ALU_ADD;
                        end
                        OP_SUB: begin
                            acc_we = 1'b1;
                            alu_op = ALU_SUB;
                        end
                        OP_AND: begin
                            acc_we = 1'b1;
                            alu_op = ALU_AND;
                        end
                        OP_OR: begin
                            acc_we = 1'b1;
                            alu_op = ALU_OR;
                        end
                        OP_MOV: reg_we = 1'b1;
                        OP_MVA: begin
                            acc_we  = 1'b1;
                            acc_src = ACC_SRC_REG;
                        end
                        OP_BEQZ: begin
                            if (acc_zero) begin
                                pc_we  = 1'b1;
                                pc_src = PC_SRC_REL;
                            end
                        end
                        OP_JMP: begin
                            pc_we  = 1'b1;
                            pc_src = PC_SRC_ABS;
                        end
                        OP_FLG: begin
                            acc_we  = 1'b1;
                            acc_src = ACC_SRC_EXT;
                            ext_sel = EXT_FLAG;
                        end
                        default: ;
                    endcase
                end
                ST_MEM: begin
                    mem_req  = 1'b1;
                    addr_sel = 1'b1;
                    mem_we   = (opcode == OP_SW);
                    if (mem_ready && (opcode == OP_LW)) begin
                        acc_we  = 1'b1;
                        acc_src = ACC_SRC_MEM;
                    end
                end
                ST_HALT:  halted = 1'b1;
                ST_FAULT: fault  = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// Self-checking bench for acc_seq_ctrl: per-cycle expected control vectors via a scoreboard.
module tb_acc_seq_ctrl;

    localparam int unsigned MAX_WAIT = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] opcode;
    logic       acc_zero;
    logic       mem_ready;
    logic       mem_req, mem_we, addr_sel, ir_we, pc_we, acc_we, ext_sel, reg_we, halted, fault;
    logic [1:0] pc_src, acc_src, alu_op;
    logic [2:0] state_dbg;

    acc_seq_ctrl #(.MAX_WAIT(MAX_WAIT), .WAIT_W(8)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .acc_zero(acc_zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_we(ir_we), .pc_we(pc_we),
        .pc_src(pc_src), .acc_we(acc_we), .acc_src(acc_src), .alu_op(alu_op), .ext_sel(ext_sel),
        .reg_we(reg_we), .halted(halted), .fault(fault), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       req, we, asel, irwe, pcwe;
        logic [1:0] pcsrc;
        logic       accwe;
        logic [1:0] accsrc, aluop;
        logic       ext, regwe, halted, fault;
    } vec_t;

    typedef struct packed {
        logic       r;
        logic       rdy;
        logic [3:0] op;
        logic       z;
        vec_t       e;
    } step_t;

    vec_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t ev(input logic [2:0] st, input logic req, we, asel, irwe, pcwe,
                                input logic [1:0] pcsrc, input logic accwe,
                                input logic [1:0] accsrc, aluop, input logic ext, regwe);
        vec_t v;
        v.st = st; v.req = req; v.we = we; v.asel = asel; v.irwe = irwe; v.pcwe = pcwe;
        v.pcsrc = pcsrc; v.accwe = accwe; v.accsrc = accsrc; v.aluop = aluop;
        v.ext = ext; v.regwe = regwe;
        v.halted = (st == 3'd4);
        v.fault  = (st == 3'd5);
        return v;
    endfunction

    function automatic vec_t z0();  return ev(3'd0, 0,0,0,0,0, 2'd0, 0, 2'd0, 2'd0, 0,0); endfunction
    function automatic vec_t fw();  return ev(3'd0, 1,0,0,0,0, 2'd0, 0, 2'd0, 2'd0, 0,0); endfunction
    function automatic vec_t fd();  return ev(3'd0, 1,0,0,1,1, 2'd0, 0, 2'd0, 2'd0, 0,0); endfunction
    function automatic vec_t dec(); return ev(3'd1, 0,0,0,0,0, 2'd0, 0, 2'd0, 2'd0, 0,0); endfunction
    function automatic vec_t ex0(); return ev(3'd2, 0,0,0,0,0, 2'd0, 0, 2'd0, 2'd0, 0,0); endfunction
    function automatic vec_t mw();  return ev(3'd3, 1,0,1,0,0, 2'd0, 0, 2'd0, 2'd0, 0,0); endfunction

    function automatic step_t sp(input logic r, rdy, input logic [3:0] op, input logic z, input vec_t e);
        step_t s;
        s.r = r; s.rdy = rdy; s.op = op; s.z = z; s.e = e;
        return s;
    endfunction

    function automatic vec_t sample();
        vec_t v;
        v.st = state_dbg; v.req = mem_req; v.we = mem_we; v.asel = addr_sel; v.irwe = ir_we;
        v.pcwe = pc_we; v.pcsrc = pc_src; v.accwe = acc_we; v.accsrc = acc_src;
        v.aluop = alu_op; v.ext = ext_sel; v.regwe = reg_we; v.halted = halted; v.fault = fault;
        return v;
    endfunction

    // Drive one cycle of inputs just after the edge, record what must appear, settle to the falling edge.
    task automatic drive(input step_t s);
        @(posedge clk);
        #1;
        rst = s.r; mem_ready = s.rdy; opcode = s.op; acc_zero = s.z;
        sb.push_back(s.e);
        @(negedge clk);
    endtask

    task automatic test_reset();
        step_t s[$];
        vec_t  exp, obs;
        repeat (3) s.push_back(sp(1, 1, 4'h8, 0, z0()));
        s.push_back(sp(0, 1, 4'h0, 0, fd()));
        s.push_back(sp(0, 1, 4'h0, 0, dec()));
        s.push_back(sp(0, 1, 4'h0, 0, ex0()));
        foreach (s[i]) begin
            drive(s[i]);
            exp = sb.pop_front(); obs = sample(); checks++;
            if (obs !== exp) begin errors++; $display("FAIL reset[%0d] got %h want %h", i, obs, exp); end
        end
    endtask

    task automatic test_ldi_stall();
        step_t s[$];
        vec_t  exp, obs;
        repeat (4) s.push_back(sp(0, 0, 4'h1, 0, fw()));
        s.push_back(sp(0, 1, 4'h1, 0, fd()));
        s.push_back(sp(0, 0, 4'h1, 0, dec()));
        s.push_back(sp(0, 0, 4'h1, 0, ev(3'd2, 0,0,0,0,0, 2'd0, 1, 2'd1, 2'd0, 0,0)));
        foreach (s[i]) begin
            drive(s[i]);
            exp = sb.pop_front(); obs = sample(); checks++;
            if (obs !== exp) begin errors++; $display("FAIL ldi_stall[%0d] got %h want %h", i, obs, exp); end
        end
    endtask

    task automatic test_alu_moves();
        step_t s[$];
        vec_t  exp, obs, e;
        for (int op = 2; op <= 7; op++) begin
            if (op <= 5)      e = ev(3'd2, 0,0,0,0,0, 2'd0, 1, 2'd0, 2'(op - 2), 0,0);
            else if (op == 6) e = ev(3'd2, 0,0,0,0,0, 2'd0, 0, 2'd0, 2'd0, 0,1);
            else              e = ev(3'd2, 0,0,0,0,0, 2'd0, 1, 2'd3, 2'd0, 0,0);
            s.push_back(sp(0, 1, 4'(op), 0, fd()));
            s.push_back(sp(0, 1, 4'(op), 0, dec()));
            s.push_back(sp(0, 1, 4'(op), 0, e));
        end
        foreach (s[i]) begin
            drive(s[i]);
            exp = sb.pop_front(); obs = sample(); checks++;
            if (obs !== exp) begin errors++; $display("FAIL alu_moves[%0d] got %h want %h", i, obs, exp); end
        end
    endtask

    task automatic test_flg_branch();
        step_t s[$];
        vec_t  exp, obs;
        s.push_back(sp(0, 1, 4'hC, 0, fd()));
        s.push_back(sp(0, 0, 4'hC, 0, dec()));
        s.push_back(sp(0, 0, 4'hC, 0, ev(3'd2, 0,0,0,0,0, 2'd0, 1, 2'd1, 2'd0, 1,0)));
        s.push_back(sp(0, 1, 4'hA, 0, fd()));
        s.push_back(sp(0, 0, 4'hA, 0, dec()));
        s.push_back(sp(0, 0, 4'hA, 0, ex0()));
        s.push_back(sp(0, 1, 4'hA, 1, fd()));
        s.push_back(sp(0, 0, 4'hA, 1, dec()));
        s.push_back(sp(0, 0, 4'hA, 1, ev(3'd2, 0,0,0,0,1, 2'd1, 0, 2'd0, 2'd0, 0,0)));
        s.push_back(sp(0, 1, 4'hB, 0, fd()));
        s.push_back(sp(0, 0, 4'hB, 0, dec()));
        s.push_back(sp(0, 0, 4'hB, 0, ev(3'd2, 0,0,0,0,1, 2'd2, 0, 2'd0, 2'd0, 0,0)));
        foreach (s[i]) begin
            drive(s[i]);
            exp = sb.pop_front(); obs = sample(); checks++;
            if (obs !== exp) begin errors++; $display("FAIL flg_branch[%0d] got %h want %h", i, obs, exp); end
        end
    endtask

    task automatic test_load_store();
        step_t s[$];
        vec_t  exp, obs;
        s.push_back(sp(0, 1, 4'h8, 0, fd()));
        s.push_back(sp(0, 1, 4'h8, 0, dec()));
        s.push_back(sp(0, 1, 4'h8, 0, ex0()));
        repeat (2) s.push_back(sp(0, 0, 4'h8, 0, mw()));
        s.push_back(sp(0, 1, 4'h8, 0, ev(3'd3, 1,0,1,0,0, 2'd0, 1, 2'd2, 2'd0, 0,0)));
        s.push_back(sp(0, 1, 4'h9, 0, fd()));
        s.push_back(sp(0, 0, 4'h9, 0, dec()));
        s.push_back(sp(0, 0, 4'h9, 0, ex0()));
        s.push_back(sp(0, 1, 4'h9, 0, ev(3'd3, 1,1,1,0,0, 2'd0, 0, 2'd0, 2'd0, 0,0)));
        foreach (s[i]) begin
            drive(s[i]);
            exp = sb.pop_front(); obs = sample(); checks++;
            if (obs !== exp) begin errors++; $display("FAIL load_store[%0d] got %h want %h", i, obs, exp); end
        end
    endtask

    task automatic test_timeout();
        step_t s[$];
        vec_t  exp, obs;
        // MEM: 15 stalled cycles, ready on the limit cycle still completes the load.
        s.push_back(sp(0, 1, 4'h8, 0, fd()));
        s.push_back(sp(0, 0, 4'h8, 0, dec()));
        s.push_back(sp(0, 0, 4'h8, 0, ex0()));
        repeat (MAX_WAIT) s.push_back(sp(0, 0, 4'h8, 0, mw()));
        s.push_back(sp(0, 1, 4'h8, 0, ev(3'd3, 1,0,1,0,0, 2'd0, 1, 2'd2, 2'd0, 0,0)));
        // FETCH: same boundary.
        repeat (MAX_WAIT) s.push_back(sp(0, 0, 4'h0, 0, fw()));
        s.push_back(sp(0, 1, 4'h0, 0, fd()));
        s.push_back(sp(0, 0, 4'h0, 0, dec()));
        s.push_back(sp(0, 0, 4'h0, 0, ex0()));
        // FETCH never acknowledged: one cycle past the limit, then terminal FAULT.
        repeat (MAX_WAIT + 1) s.push_back(sp(0, 0, 4'h0, 0, fw()));
        for (int k = 0; k < 6; k++) s.push_back(sp(0, 1'(k), 4'h1, 0, ev(3'd5, 0,0,0,0,0, 2'd0, 0, 2'd0, 2'd0, 0,0)));
        s.push_back(sp(1, 0, 4'h0, 0, z0()));
        foreach (s[i]) begin
            drive(s[i]);
            exp = sb.pop_front(); obs = sample(); checks++;
            if (obs !== exp) begin errors++; $display("FAIL timeout[%0d] got %h want %h", i, obs, exp); end
        end
    endtask

    task automatic test_terminal();
        step_t s[$];
        vec_t  exp, obs;
        s.push_back(sp(0, 1, 4'hF, 0, fd()));
        s.push_back(sp(0, 0, 4'hF, 0, dec()));
        s.push_back(sp(0, 0, 4'hF, 0, ex0()));
        for (int k = 0; k < 20; k++)
            s.push_back(sp(0, 1'(k), 4'($urandom_range(0, 15)), 1'(k >> 1), ev(3'd4, 0,0,0,0,0, 2'd0, 0, 2'd0, 2'd0, 0,0)));
        s.push_back(sp(1, 1, 4'h0, 0, z0()));
        s.push_back(sp(0, 1, 4'hD, 0, fd()));
        s.push_back(sp(0, 0, 4'hD, 0, dec()));
        s.push_back(sp(0, 0, 4'hD, 0, ex0()));
        repeat (3) s.push_back(sp(0, 1, 4'h8, 0, ev(3'd5, 0,0,0,0,0, 2'd0, 0, 2'd0, 2'd0, 0,0)));
        s.push_back(sp(1, 0, 4'h0, 0, z0()));
        foreach (s[i]) begin
            drive(s[i]);
            exp = sb.pop_front(); obs = sample(); checks++;
            if (obs !== exp) begin errors++; $display("FAIL terminal[%0d] got %h want %h", i, obs, exp); end
        end
    endtask

    task automatic test_reset_mid_mem();
        step_t s[$];
        vec_t  exp, obs;
        s.push_back(sp(0, 1, 4'h8, 0, fd()));
        s.push_back(sp(0, 0, 4'h8, 0, dec()));
        s.push_back(sp(0, 0, 4'h8, 0, ex0()));
        s.push_back(sp(0, 0, 4'h8, 0, mw()));
        s.push_back(sp(1, 1, 4'h8, 0, z0()));
        s.push_back(sp(0, 0, 4'h8, 0, fw()));
        s.push_back(sp(0, 1, 4'h0, 0, fd()));
        s.push_back(sp(0, 0, 4'h0, 0, dec()));
        s.push_back(sp(0, 0, 4'h0, 0, ex0()));
        foreach (s[i]) begin
            drive(s[i]);
            exp = sb.pop_front(); obs = sample(); checks++;
            if (obs !== exp) begin errors++; $display("FAIL reset_mid_mem[%0d] got %h want %h", i, obs, exp); end
        end
    endtask

    initial begin
        rst = 1'b1; mem_ready = 1'b0; opcode = 4'h0; acc_zero = 1'b0;
        test_reset();
        test_ldi_stall();
        test_alu_moves();
        test_flg_branch();
        test_load_store();
        test_timeout();
        test_terminal();
        test_reset_mid_mem();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
